// File: rtl/a0_trace_buffer.sv
// a0_trace_buffer
//   Watches the core's a0 register every clock, queues each new value in a
//   first-word-fall-through FIFO and lets a consumer drain entries through a
//   valid/ready handshake. Never stalls the core. When the FIFO is full and
//   nothing is popped, a change is dropped and recorded in overflow/drop_count.
//
//   Optional feature macro: A0_TRACE_TIMESTAMP_EN
//     defined   - free-running timestamp counter; each entry stores the
//                 timestamp of its push edge, presented on trace_time
//     undefined - no counter or timestamp storage; trace_time is tied to 0
//
// Parameters: WIDTH (a0 width), DEPTH (entries, power of two >= 2),
//             TS_WIDTH (timestamp width)
// Ports:
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   a0           core a0 value, sampled every edge
//   trace_valid  head entry present
//   trace_ready  consumer accepts head entry
//   trace_data   head entry value
//   trace_time   head entry timestamp (0 when timestamps are not built)
//   count        occupancy 0..DEPTH
//   overflow     sticky, at least one change dropped
//   drop_count   dropped changes, saturating at 255
module a0_trace_buffer #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned TS_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           a0,
  output logic                       trace_valid,
  input  logic                       trace_ready,
  output logic [WIDTH-1:0]           trace_data,
  output logic [TS_WIDTH-1:0]        trace_time,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [7:0]                 drop_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] prev;
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [WIDTH-1:0] mem_data [DEPTH];

  logic change;
  logic full;
  logic pop;
  logic push;
  logic drop;
  logic [PW-1:0] count_next;

  assign change = (a0 != prev);
  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop    = trace_valid && trace_ready;
  // A pop frees the slot in the same edge, so a full FIFO can still accept.
  assign push   = change && (!full || pop);
  assign drop   = change && full && !pop;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev        <= '0;
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      trace_valid <= 1'b0;
      overflow    <= 1'b0;
      drop_count  <= '0;
    end else begin
      prev        <= a0;
      count       <= count_next;
      trace_valid <= (count_next != '0);
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) mem_data[wptr[AW-1:0]] <= a0;
  end

  assign trace_data = mem_data[rptr[AW-1:0]];

`ifdef A0_TRACE_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts;
  logic [TS_WIDTH-1:0] mem_time [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts <= '0;
    else     ts <= ts + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_time[wptr[AW-1:0]] <= ts;
  end

  assign trace_time = mem_time[rptr[AW-1:0]];
`else
  assign trace_time = '0;
`endif

endmodule
